// File: rtl/arm_fetch_stage.sv
// ARM IF stage: PC, instruction-memory request/ready handshake, IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module arm_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_req,
  input  logic [31:0]       inst_in,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       inst_out,
  output logic              valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_REDIRECT} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pending_reg;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;

  assign inst_addr = pc_reg;
  assign inst_req  = ~rst;
  assign pc_plus4  = pc_reg + ADDR_W'(4);
  assign target    = {branch_addr[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_RUN;
      pc_reg      <= PC_RESET;
      pending_reg <= '0;
      pc_out      <= '0;
      inst_out    <= '0;
      valid_out   <= 1'b0;
    end else begin
      case (state_reg)
        // RUN and WAIT only differ in whether the request is fresh; their transitions coincide.
        S_RUN, S_WAIT: begin
          if (branch_taken) begin
            pc_out    <= '0;
            inst_out  <= '0;
            valid_out <= 1'b0;
            if (mem_ready) begin
              pc_reg    <= target;
              state_reg <= S_RUN;
            end else begin
              pending_reg <= target;
              state_reg   <= S_REDIRECT;
            end
          end else if (freeze) begin
            state_reg <= state_reg;
          end else if (mem_ready) begin
            pc_reg    <= pc_plus4;
            pc_out    <= pc_plus4;
            inst_out  <= inst_in;
            valid_out <= 1'b1;
            state_reg <= S_RUN;
          end else begin
            pc_out    <= '0;
            inst_out  <= '0;
            valid_out <= 1'b0;
            state_reg <= S_WAIT;
          end
        end
        // A stale fetch is in flight: its data is dropped and PC jumps once it completes.
        S_REDIRECT: begin
          pc_out    <= '0;
          inst_out  <= '0;
          valid_out <= 1'b0;
          if (mem_ready) begin
            pc_reg    <= branch_taken ? target : pending_reg;
            state_reg <= S_RUN;
          end else if (branch_taken) begin
            pending_reg <= target;
          end
        end
        default: state_reg <= S_RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic load_valid;

  assign load_valid = mem_ready && (state_reg != S_REDIRECT) && !branch_taken && !freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else if (load_valid) begin
      fetch_count <= fetch_count + 32'd1;
    end else begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Bench for arm_fetch_stage: directed vector table for the corner cases, then random traffic vs a reference model.
module tb_arm_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] inst_addr;
  logic        inst_req;
  logic [31:0] inst_in;
  logic        mem_ready;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'd0) return 32'hE3A00014;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory model: data only meaningful when ready, garbage otherwise.
  assign inst_in = mem_ready ? rom(inst_addr) : 32'hBAD0BAD0;

  arm_fetch_stage #(.ADDR_W(32), .PC_RESET(32'd0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .inst_addr(inst_addr), .inst_req(inst_req),
    .inst_in(inst_in), .mem_ready(mem_ready), .pc_out(pc_out),
    .inst_out(inst_out), .valid_out(valid_out)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic        r, f, b;
    logic [31:0] ba;
    logic        m;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_src;
  } vec_t;

  function automatic vec_t mk(input logic r, f, b, input logic [31:0] ba, input logic m,
                              input logic [31:0] ea, input logic ev, input logic [31:0] epc, esrc);
    vec_t v;
    v.r = r; v.f = f; v.b = b; v.ba = ba; v.m = m;
    v.e_addr = ea; v.e_valid = ev; v.e_pc = epc; v.e_src = esrc;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, f, b, input logic [31:0] ba, input logic m);
    rst = r; freeze = f; branch_taken = b; branch_addr = ba; mem_ready = m;
    #1;
    check32("inst_req", {31'd0, inst_req}, {31'd0, ~r});
    @(posedge clk);
    #1;
  endtask

  vec_t tv[$];

  // Reference model state: PC plus an optional outstanding redirect target.
  logic [31:0] m_pc, m_tgt, m_pco, m_io, t_addr;
  logic        m_redir, m_valid, loaded;
  logic [31:0] m_fc, m_sc;

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; mem_ready = 1'b0;

    //                r  f  b  ba            m   addr          v  pc_out  src
    tv.push_back(mk(1, 0, 0, 0,            1, 0,            0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 4,            1, 4,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 8,            1, 8,    4));
    tv.push_back(mk(0, 0, 0, 0,            1, 12,           1, 12,   8));
    tv.push_back(mk(0, 1, 0, 0,            1, 12,           1, 12,   8));
    tv.push_back(mk(0, 1, 0, 0,            1, 12,           1, 12,   8));
    tv.push_back(mk(0, 1, 0, 0,            1, 12,           1, 12,   8));
    tv.push_back(mk(0, 0, 0, 0,            1, 16,           1, 16,   12));
    tv.push_back(mk(0, 0, 0, 0,            1, 20,           1, 20,   16));
    tv.push_back(mk(0, 0, 1, 148,          1, 148,          0, 0,    0));
    tv.push_back(mk(0, 0, 1, 112,          1, 112,          0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 116,          1, 116,  112));
    tv.push_back(mk(0, 0, 1, 40,           1, 40,           0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            0, 40,           0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            0, 40,           0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 44,           1, 44,   40));
    tv.push_back(mk(0, 0, 1, 64,           1, 64,           0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            0, 64,           0, 0,    0));
    tv.push_back(mk(0, 0, 1, 0,            0, 64,           0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 0,            0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 4,            1, 4,    0));
    tv.push_back(mk(0, 0, 1, 32'h103,      1, 32'h100,      0, 0,    0));
    tv.push_back(mk(0, 0, 1, 200,          0, 32'h100,      0, 0,    0));
    tv.push_back(mk(0, 1, 0, 0,            0, 32'h100,      0, 0,    0));
    tv.push_back(mk(0, 1, 0, 0,            1, 200,          0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 204,          1, 204,  200));
    tv.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 0,            1, 0,    32'hFFFFFFFC));
    tv.push_back(mk(0, 0, 1, 80,           0, 0,            0, 0,    0));
    tv.push_back(mk(1, 0, 0, 0,            1, 0,            0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 4,            1, 4,    0));
    tv.push_back(mk(0, 0, 0, 0,            0, 4,            0, 0,    0));
    tv.push_back(mk(0, 1, 0, 0,            1, 4,            0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 8,            1, 8,    4));
    tv.push_back(mk(0, 0, 1, 300,          0, 8,            0, 0,    0));
    tv.push_back(mk(0, 0, 1, 400,          0, 8,            0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 400,          0, 0,    0));
    tv.push_back(mk(0, 0, 1, 500,          0, 400,          0, 0,    0));
    tv.push_back(mk(0, 0, 1, 600,          1, 600,          0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,            1, 604,          1, 604,  600));
    tv.push_back(mk(0, 1, 0, 0,            0, 604,          1, 604,  600));

    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].f, tv[i].b, tv[i].ba, tv[i].m);
      check32($sformatf("v%0d inst_addr", i), inst_addr, tv[i].e_addr);
      check32($sformatf("v%0d pc_out", i), pc_out, tv[i].e_pc);
      check32($sformatf("v%0d inst_out", i), inst_out,
              tv[i].e_valid ? rom(tv[i].e_src) : 32'd0);
      check32($sformatf("v%0d valid_out", i), {31'd0, valid_out}, {31'd0, tv[i].e_valid});
    end

    // Random traffic, starting from a reset so the model and DUT agree.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    m_pc = 0; m_tgt = 0; m_redir = 0; m_pco = 0; m_io = 0; m_valid = 0; m_fc = 0; m_sc = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, f, b, m;
      logic [31:0] ba;
      r  = ($urandom_range(63) == 0);
      f  = ($urandom_range(4) == 0);
      b  = ($urandom_range(7) == 0);
      m  = ($urandom_range(3) != 0);
      ba = $urandom;
      if ($urandom_range(7) == 0) ba = 32'hFFFFFFF0 | {28'd0, ba[3:0]};

      check32($sformatf("r%0d inst_addr", n), inst_addr, m_pc);

      loaded = 1'b0;
      t_addr = {ba[31:2], 2'b00};
      if (r) begin
        m_pc = 0; m_redir = 0; m_pco = 0; m_io = 0; m_valid = 0; m_fc = 0; m_sc = 0;
      end else begin
        if (m_redir) begin
          m_pco = 0; m_io = 0; m_valid = 0;
          if (b) m_tgt = t_addr;
          if (m) begin m_pc = m_tgt; m_redir = 0; end
        end else if (b) begin
          m_pco = 0; m_io = 0; m_valid = 0;
          if (m) m_pc = t_addr;
          else begin m_redir = 1; m_tgt = t_addr; end
        end else if (f) begin
          m_valid = m_valid;
        end else if (m) begin
          m_io = rom(m_pc); m_pco = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4; loaded = 1;
        end else begin
          m_pco = 0; m_io = 0; m_valid = 0;
        end
        if (loaded) m_fc = m_fc + 1;
        else m_sc = m_sc + 1;
      end

      drive(r, f, b, ba, m);
      check32($sformatf("r%0d pc_out", n), pc_out, m_pco);
      check32($sformatf("r%0d inst_out", n), inst_out, m_io);
      check32($sformatf("r%0d valid_out", n), {31'd0, valid_out}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      check32($sformatf("r%0d fetch_count", n), fetch_count, m_fc);
      check32($sformatf("r%0d stall_count", n), stall_count, m_sc);
`endif
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/arm_fetch_stage.md
Name: arm_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the ARM pipeline; the reading side of the instruction memory.
- Holds the PC and drives byte addresses to instruction memory with a request/ready handshake. Supports both the combinational ROM (mem_ready tied 1) and future multi-cycle SRAM.
- Registers fetched instructions into the IF/ID pipeline register.
- Handles hazard freeze from ID and branch redirect/flush from EXE.

Parameters:
- PC_RESET, 32'd0, PC value loaded on reset.
- ADDR_W, 32, width of PC and memory address.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- freeze  input  1  ID hazard stall; holds PC and IF/ID.
- branch_taken  input  1  EXE redirect request, single-cycle pulse.
- branch_addr  input  ADDR_W  redirect target byte address, word-aligned.
- inst_addr  output  ADDR_W  instruction memory byte address, always equal to the PC register.
- inst_req  output  1  fetch request to memory.
- inst_in  input  32  instruction word; valid only when mem_ready=1.
- mem_ready  input  1  memory returns inst_in for inst_addr this cycle.
- pc_out  output  ADDR_W  IF/ID: fetch address + 4.
- inst_out  output  32  IF/ID: instruction word.
- valid_out  output  1  IF/ID: 1 = real instruction, 0 = bubble.

Behaviour:
- Reset, applied at a clk edge with rst=1:
  - PC=PC_RESET, state=RUN.
  - pc_out=0, inst_out=0, valid_out=0, pending target=0.
  - Reset overrides every other input, including mid-WAIT and mid-REDIRECT.
- inst_req is 1 in every state when rst=0. Combinationally, inst_req=0 while rst=1.
- inst_addr=PC. It stays stable while a request is outstanding (state WAIT or REDIRECT).
- An accept occurs when mem_ready=1 and the state is RUN or WAIT.
- State RUN, evaluated per cycle:
  - branch_taken=1 (highest priority, beats freeze and any accept):
    - if mem_ready=1: PC<=branch_addr, IF/ID<=bubble, stay RUN.
    - if mem_ready=0: pending<=branch_addr, IF/ID<=bubble, go REDIRECT.
  - else freeze=1: PC and IF/ID hold; any mem_ready this cycle is ignored and the same address is refetched.
  - else mem_ready=1: PC<=PC+4; IF/ID<={PC+4, inst_in, 1}.
  - else (mem_ready=0): IF/ID<=bubble, go WAIT.
- State WAIT (request outstanding):
  - branch_taken=1 with mem_ready=1: response discarded, PC<=branch_addr, bubble, go RUN.
  - branch_taken=1 with mem_ready=0: pending<=branch_addr, bubble, go REDIRECT.
  - freeze=1, no branch: IF/ID holds, PC holds, stay WAIT; mem_ready is ignored.
  - mem_ready=1: PC<=PC+4, IF/ID<={PC+4, inst_in, 1}, go RUN.
  - otherwise: IF/ID<=bubble, stay WAIT.
- State REDIRECT (stale request in flight):
  - IF/ID<=bubble every cycle; freeze is ignored.
  - A second branch_taken overwrites pending.
  - On mem_ready=1: data discarded, PC<=pending (or branch_addr if branch_taken the same cycle), go RUN.
- Bubble encoding is pc_out=0, inst_out=0, valid_out=0.
- Arithmetic:
  - PC+4 is modulo 2^ADDR_W; 32'hFFFFFFFC wraps to 0.
  - branch_addr[1:0] is ignored and forced to 00.
- Latency with mem_ready=1: an instruction fetched in cycle N appears on IF/ID after edge N+1. Throughput is 1 instruction per cycle.
- Flush takes effect one edge after branch_taken. Branch-shadow instructions never reach IF/ID with valid_out=1.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two ports:
  - fetch_count  output  32: increments on every IF/ID load with valid=1.
  - stall_count  output  32: increments on every cycle with rst=0 where no valid load occurs.
  - Both are 0 on reset and wrap at 2^32.
- When undefined, neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- Reset, then 6 cycles with mem_ready=1 and the ROM at addresses 0..20 → inst_addr goes 0,4,8,12,16,20. The first IF/ID has pc_out=4 and inst_out=32'hE3A00014, with valid_out=1 from cycle 1 onward.
- freeze=1 for 3 cycles while PC=12 → inst_addr stays 12, and IF/ID holds pc_out=12 with the word from address 8. On release, the next load is pc_out=16.
- branch_taken=1 with branch_addr=112 while PC=148 and mem_ready=1 → next inst_addr=112 and valid_out=0 for one cycle. Then pc_out=116 with the word from address 112.
- mem_ready=0 for 2 cycles at PC=40 → inst_addr stays 40 and valid_out=0 for 2 cycles. When mem_ready=1, IF/ID gets pc_out=44 and the state returns to RUN.
- In WAIT at PC=64, branch_taken with branch_addr=0 and mem_ready=0, then mem_ready=1 one cycle later → the response from 64 is discarded (valid_out stays 0), then inst_addr=0.
- PC=32'hFFFFFFFC with mem_ready=1 → next PC=0. rst asserted while in REDIRECT → PC=0, valid_out=0, state RUN on the next edge.
